frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Streams one full frame out of the frame buffer, in raster order, after each start request.
- Counterpart to the frame clear engine: the clear engine sweeps DrawX/DrawY and writes; this block sweeps ReadX/ReadY and reads.
- Issues pipelined reads to the frame buffer read port and buffers the returned pixels in a small FIFO.
- Delivers pixels to the VGA/scanout side over a valid/ready stream, with start/done handshaking toward the top-level sequencer.

Parameters:
- H_PIXELS, 640, pixels per line
- V_PIXELS, 480, lines per frame
- PIXEL_W, 16, frame buffer pixel width
- READ_LATENCY, 2, cycles from fb_rd_en to fb_rd_data valid (fixed; >= 1)
- FIFO_DEPTH, 16, output FIFO entries (power of two)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_read_start  in  1  level; sampled only in IDLE
- ReadX  out  10  column of current read request
- ReadY  out  10  row of current read request
- fb_rd_en  out  1  read request for (ReadX, ReadY) this cycle
- fb_rd_data  in  PIXEL_W  read data, valid READ_LATENCY cycles after fb_rd_en
- pixel_data  out  PIXEL_W  FIFO head pixel
- pixel_eol  out  1  head pixel has x == H_PIXELS-1
- pixel_last  out  1  head pixel is (H_PIXELS-1, V_PIXELS-1)
- pixel_valid  out  1  FIFO not empty
- pixel_ready  in  1  consumer accepts head this cycle
- frame_read_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state = IDLE; ReadX = ReadY = 0; fb_rd_en = 0; pixel_valid = 0; frame_read_done = 0.
- Reset also empties the FIFO and clears the in-flight valid pipeline. Read data returning after reset is discarded.
- Reset mid-frame aborts immediately. No done pulse is produced for the aborted frame.
- State IDLE: if frame_read_start, go to READ on the next edge. ReadX and ReadY are already 0.
- State READ: fb_rd_en = 1 only when (fifo_count + in_flight) < FIFO_DEPTH (credit rule). This rule guarantees the FIFO never overflows.
- On each issued read:
  - ReadX increments; at H_PIXELS-1 it wraps to 0 and ReadY increments.
  - Issuing (H_PIXELS-1, V_PIXELS-1) moves the state to DRAIN.
  - ReadX and ReadY then hold at their last values.
- In-flight tracking: a READ_LATENCY-deep shift register of {valid, eol, last} flags follows fb_rd_en. When the tail is valid, fb_rd_data plus the flags are pushed into the FIFO on that edge.
- State DRAIN: no reads are issued. When the handshake (pixel_valid && pixel_ready) occurs with pixel_last = 1, go to DONE.
- State DONE: frame_read_done = 1 for exactly one cycle; then go to IDLE with ReadX = ReadY = 0. If start is still high in IDLE, the next frame begins (back-to-back frames).
- frame_read_start outside IDLE is ignored.
- Latency: start sampled at edge 0 → READ in cycle 1 → first fb_rd_en in cycle 1 with (0,0) → data pushed at the end of cycle 1+READ_LATENCY → pixel_valid = 1 in cycle 2+READ_LATENCY (cycle 4 at default).
- FIFO is first-word fall-through: pixel_data/eol/last reflect the head whenever pixel_valid = 1. They are held stable while pixel_valid && !pixel_ready.
- Simultaneous push and pop: count is unchanged, and this is legal even when the FIFO is full. A pop with pixel_valid = 0 is ignored.
- Throughput: with pixel_ready held at 1, one read is issued per cycle and one pixel is delivered per cycle.
- fifo_count and in_flight are sized to $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package (renderer_pkg):
  - H_PIXELS/V_PIXELS constants
  - pixel_t (logic [PIXEL_W-1:0])
  - fr_state_t enum {IDLE, READ, DRAIN, DONE}
- Sub-module sync_fifo_fwft:
  - parameterised width and depth
  - ports: push, push_data, pop, head_data, empty, full, count
  - holds {last, eol, pixel}

Test Plan:
- Basic frame:
  - Stimulus: frame buffer model returns x ^ (y << 6) with READ_LATENCY = 2; pixel_ready = 1; start pulse.
  - Required: pixel_valid first asserted 4 cycles after start; exactly 307200 pixels delivered, in raster order, with matching data.
  - Required: pixel_eol on every 640th pixel; pixel_last only on the final pixel.
  - Required: frame_read_done is a single pulse one cycle after the last handshake.
- Backpressure:
  - Stimulus: pixel_ready = 0 for 100 cycles after start.
  - Required: exactly 16 fb_rd_en cycles, then none; pixel_data stable.
  - Required: after release, no loss or duplication, and reads resume.
- Random pixel_ready (50%):
  - Required: the delivered stream equals the model, and fifo_count never exceeds 16.
- Start while busy:
  - Stimulus: re-pulse frame_read_start during READ and during DRAIN.
  - Required: ignored; exactly one done pulse per frame.
- Start held high:
  - Required: two consecutive frames; ReadX/ReadY return to (0,0); one done pulse per frame.
- Reset at pixel ~1000 with reads in flight:
  - Required: next cycle pixel_valid = 0, fb_rd_en = 0, ReadX = ReadY = 0, no done pulse.
  - Required: a subsequent start yields a clean full frame.

Source files
------------

// File: rtl/renderer_pkg.sv
// Shared renderer types: screen geometry, pixel type and frame reader states.
package renderer_pkg;

  localparam int unsigned H_PIXELS = 640;
  localparam int unsigned V_PIXELS = 480;
  localparam int unsigned PIXEL_W  = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} fr_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO; head_data shows the oldest entry while not empty.
module sync_fifo_fwft
  import renderer_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_reader.sv
// Sweeps ReadX/ReadY over one frame per start, issues credit-limited reads to the
// frame buffer and streams the returned pixels out through a small FWFT FIFO.
module frame_reader #(
  parameter int unsigned H_PIXELS     = renderer_pkg::H_PIXELS,
  parameter int unsigned V_PIXELS     = renderer_pkg::V_PIXELS,
  parameter int unsigned PIXEL_W      = renderer_pkg::PIXEL_W,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_read_start,
  output logic [9:0]         ReadX,
  output logic [9:0]         ReadY,
  output logic               fb_rd_en,
  input  logic [PIXEL_W-1:0] fb_rd_data,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_eol,
  output logic               pixel_last,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               frame_read_done
);

  import renderer_pkg::*;

  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW     = PIXEL_W + 2;
  localparam logic [9:0]  X_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_PIXELS - 1);

  fr_state_t state;
  fr_state_t state_next;

  logic                    issue_eol;
  logic                    issue_last;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_eol;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [CW-1:0]           in_flight;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             credit_used;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [FW-1:0]           head;

  assign issue_eol   = (ReadX == X_LAST);
  assign issue_last  = issue_eol && (ReadY == Y_LAST);
  // Every outstanding read already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_used = {1'b0, fifo_count} + {1'b0, in_flight};

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    fb_rd_en        = 1'b0;
    frame_read_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_read_start) state_next = READ;
      end
      READ: begin
        if (credit_used < (CW + 1)'(FIFO_DEPTH)) begin
          fb_rd_en = 1'b1;
          if (issue_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && head[FW-1]) state_next = DONE;
      end
      DONE: begin
        frame_read_done = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || state == DONE) begin
      ReadX <= '0;
      ReadY <= '0;
    end else if (fb_rd_en && !issue_last) begin
      if (issue_eol) begin
        ReadX <= '0;
        ReadY <= ReadY + 10'd1;
      end else begin
        ReadX <= ReadX + 10'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pipe_vld  <= '0;
      pipe_eol  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= fb_rd_en;
      pipe_eol[0]  <= issue_eol;
      pipe_last[0] <= issue_last;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_eol[i]  <= pipe_eol[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign fifo_push = pipe_vld[READ_LATENCY-1];

  always_ff @(posedge Clk) begin
    if (Reset)                       in_flight <= '0;
    else if (fb_rd_en && !fifo_push) in_flight <= in_flight + CW'(1);
    else if (!fb_rd_en && fifo_push) in_flight <= in_flight - CW'(1);
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (fifo_push),
    .push_data ({pipe_last[READ_LATENCY-1], pipe_eol[READ_LATENCY-1], fb_rd_data}),
    .pop       (fifo_pop),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign pixel_valid = !fifo_empty;
  assign fifo_pop    = pixel_valid && pixel_ready;
  assign pixel_data  = head[PIXEL_W-1:0];
  assign pixel_eol   = head[PIXEL_W];
  assign pixel_last  = head[PIXEL_W+1];

  overflow_guard: assert property (@(posedge Clk) disable iff (Reset)
    fifo_full |-> (!fifo_push || fifo_pop));

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader on a reduced 16x6 frame with a latency-2 frame buffer model.
module tb_frame_reader;

  import renderer_pkg::*;

  localparam int unsigned TH    = 16;
  localparam int unsigned TV    = 6;
  localparam int          NPIX  = TH * TV;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_read_start;
  logic [9:0] ReadX;
  logic [9:0] ReadY;
  logic       fb_rd_en;
  pixel_t     fb_rd_data;
  pixel_t     pixel_data;
  logic       pixel_eol;
  logic       pixel_last;
  logic       pixel_valid;
  logic       pixel_ready;
  logic       frame_read_done;

  frame_reader #(
    .H_PIXELS     (TH),
    .V_PIXELS     (TV),
    .PIXEL_W      (16),
    .READ_LATENCY (LAT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_read_start (frame_read_start),
    .ReadX            (ReadX),
    .ReadY            (ReadY),
    .fb_rd_en         (fb_rd_en),
    .fb_rd_data       (fb_rd_data),
    .pixel_data       (pixel_data),
    .pixel_eol        (pixel_eol),
    .pixel_last       (pixel_last),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .frame_read_done  (frame_read_done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  int outstanding = 0;
  int last_hs  = -10;
  int ready_mode = 0;
  logic [9:0]  exp_rx = '0;
  logic [9:0]  exp_ry = '0;
  logic        held = 1'b0;
  logic [17:0] held_val;
  logic [17:0] exp_pix;
  logic [17:0] sb [$];

  function automatic pixel_t pix(input logic [9:0] x, input logic [9:0] y);
    return pixel_t'(x) ^ (pixel_t'(y) << 6);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Frame buffer model with a fixed two-cycle read latency; idle slots return a marker.
  pixel_t rd_pipe [LAT];
  always @(posedge Clk) begin
    rd_pipe[0] <= fb_rd_en ? pix(ReadX, ReadY) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_rd_data = rd_pipe[LAT-1];

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    pixel_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      case (ready_mode)
        0:       pixel_ready = 1'b1;
        1:       pixel_ready = 1'($urandom_range(0, 1));
        default: pixel_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pop, read address model, credit bound, hold stability, done timing.
  always @(negedge Clk) begin
    if (Reset) begin
      sb.delete();
      exp_rx      = '0;
      exp_ry      = '0;
      outstanding = 0;
      held        = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(pixel_valid), 32'd1);
        chk("hold_head", 32'({pixel_last, pixel_eol, pixel_data}), 32'(held_val));
      end
      held     = pixel_valid && !pixel_ready;
      held_val = {pixel_last, pixel_eol, pixel_data};
      if (pixel_valid && pixel_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pixel: got %0h expected none (t=%0t)",
                   {pixel_last, pixel_eol, pixel_data}, $time);
        end else begin
          exp_pix = sb.pop_front();
          chk("pixel", 32'({pixel_last, pixel_eol, pixel_data}), 32'(exp_pix));
          if (pixel_last) last_hs = cyc;
        end
        outstanding--;
      end
      if (fb_rd_en) begin
        chk("read_addr", 32'({ReadY, ReadX}), 32'({exp_ry, exp_rx}));
        if (exp_rx == 10'(TH - 1)) begin
          exp_rx = '0;
          exp_ry = (exp_ry == 10'(TV - 1)) ? 10'd0 : exp_ry + 10'd1;
        end else begin
          exp_rx = exp_rx + 10'd1;
        end
        outstanding++;
        rd_cnt++;
        chk("credit_bound", 32'(outstanding > int'(DEPTH)), 32'd0);
      end
      if (frame_read_done) begin
        chk("done_timing", 32'(cyc), 32'(last_hs + 1));
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame();
    for (int y = 0; y < int'(TV); y++)
      for (int x = 0; x < int'(TH); x++)
        sb.push_back({1'(x == int'(TH) - 1 && y == int'(TV) - 1), 1'(x == int'(TH) - 1),
                      pix(10'(x), 10'(y))});
  endtask

  task automatic pulse_start();
    frame_read_start = 1'b1;
    tick();
    frame_read_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    for (int k = 0; k < budget && done_cnt == base; k++) @(posedge Clk);
    if (done_cnt == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no frame_read_done within %0d cycles", budget);
    end
    #1;
  endtask

  typedef struct {
    logic       start;
    logic       rd_en;
    logic [9:0] x;
    logic       valid;
    logic       done;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int base_done;
    int base_rd;
    bit found;

    // Cycle 0 presents start; reads begin in cycle 1, first pixel visible in cycle 4.
    vecs[0] = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 10'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 10'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 10'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 10'd3, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 10'd4, 1'b1, 1'b0};

    Reset = 1'b1;
    frame_read_start = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_rd_en", 32'(fb_rd_en), 32'd0);
    chk("rst_xy", 32'({ReadY, ReadX}), 32'd0);
    chk("rst_done", 32'(frame_read_done), 32'd0);

    // Basic frame with latency table
    push_frame();
    base_done = done_cnt;
    foreach (vecs[i]) begin
      tick();
      frame_read_start = vecs[i].start;
      @(negedge Clk);
      chk("lat_rd_en", 32'(fb_rd_en), 32'(vecs[i].rd_en));
      chk("lat_x", 32'(ReadX), 32'(vecs[i].x));
      chk("lat_valid", 32'(pixel_valid), 32'(vecs[i].valid));
      chk("lat_done", 32'(frame_read_done), 32'(vecs[i].done));
    end
    wait_done(NPIX + 50);
    @(negedge Clk);
    chk("basic_all_delivered", 32'(sb.size()), 32'd0);
    chk("basic_xy_home", 32'({ReadY, ReadX}), 32'd0);
    chk("basic_done_count", 32'(done_cnt - base_done), 32'd1);

    // Backpressure: consumer stalled for 100 cycles
    ready_mode = 2;
    tick();
    tick();
    push_frame();
    base_rd = rd_cnt;
    pulse_start();
    repeat (100) tick();
    chk("bp_reads", 32'(rd_cnt - base_rd), 32'(DEPTH));
    chk("bp_valid", 32'(pixel_valid), 32'd1);
    ready_mode = 0;
    wait_done(NPIX + 50);
    chk("bp_all_delivered", 32'(sb.size()), 32'd0);
    chk("bp_reads_total", 32'(rd_cnt - base_rd), 32'(NPIX));

    // Random 50% consumer
    ready_mode = 1;
    push_frame();
    pulse_start();
    wait_done(NPIX * 8);
    ready_mode = 0;
    chk("rand_all_delivered", 32'(sb.size()), 32'd0);

    // Start re-pulsed during READ and during DRAIN
    tick();
    push_frame();
    base_done = done_cnt;
    base_rd = rd_cnt;
    pulse_start();
    repeat (20) tick();
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < NPIX * 4; k++) begin
      @(negedge Clk);
      if (fb_rd_en && ReadX == 10'(TH - 1) && ReadY == 10'(TV - 1)) begin
        found = 1'b1;
        break;
      end
    end
    chk("busy_last_read_seen", 32'(found), 32'd1);
    tick();
    pulse_start();
    wait_done(NPIX + 50);
    repeat (20) tick();
    chk("busy_done_count", 32'(done_cnt - base_done), 32'd1);
    chk("busy_reads", 32'(rd_cnt - base_rd), 32'(NPIX));

    // Start held high: back-to-back frames
    push_frame();
    push_frame();
    base_done = done_cnt;
    base_rd = rd_cnt;
    frame_read_start = 1'b1;
    wait_done(NPIX + 50);
    @(negedge Clk);
    chk("held_xy_home", 32'({ReadY, ReadX}), 32'd0);
    wait_done(NPIX + 50);
    frame_read_start = 1'b0;
    repeat (10) tick();
    chk("held_done_count", 32'(done_cnt - base_done), 32'd2);
    chk("held_reads", 32'(rd_cnt - base_rd), 32'(2 * NPIX));
    chk("held_all_delivered", 32'(sb.size()), 32'd0);

    // Reset mid-frame with reads in flight
    push_frame();
    base_done = done_cnt;
    pulse_start();
    for (int k = 0; k < 500 && sb.size() > NPIX - 40; k++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_valid", 32'(pixel_valid), 32'd0);
    chk("abort_rd_en", 32'(fb_rd_en), 32'd0);
    chk("abort_xy", 32'({ReadY, ReadX}), 32'd0);
    chk("abort_done", 32'(frame_read_done), 32'd0);
    repeat (10) tick();
    chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    push_frame();
    pulse_start();
    wait_done(NPIX + 50);
    chk("abort_clean_frame", 32'(sb.size()), 32'd0);
    chk("abort_done_count", 32'(done_cnt - base_done), 32'd1);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
